// File: rtl/tiny_rv_decode_stage.sv
// RV32I decode stage: decodes fetched instructions into a 2-entry skid buffer,
// resolves JAL targets locally and forwards execute redirects to fetch.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_fetched_pc/_inst      instruction from fetch (inst 0 = bubble)
//   o_pipe_stall/_flush     registered hold / flush controls to fetch
//   o_ld_new_addr/o_new_addr registered redirect pulse and target to fetch
//   i_ex_ready              execute takes the head entry this cycle
//   i_ex_redirect(_addr)    execute-resolved redirect and its target
//   o_dec_*                 head entry: valid, pc, inst, fields, imm, illegal

package tiny_rv_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_MISC  = 7'b0001111;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] imm;
    logic        illegal;
  } dec_t;

  function automatic dec_t decode(
    input logic [31:0] pc,
    input logic [31:0] i
  );
    dec_t       d;
    logic [6:0] op;
    logic       is_i, is_s, is_b, is_u, is_j, is_r;
    op   = i[6:0];
    is_i = (op == OP_LOAD) || (op == OP_IMM) ||
           (op == OP_JALR) || (op == OP_MISC) ||
           (op == OP_SYS);
    is_s = (op == OP_STORE);
    is_b = (op == OP_BR);
    is_u = (op == OP_LUI) || (op == OP_AUIPC);
    is_j = (op == OP_JAL);
    is_r = (op == OP_OP);
    d.pc      = pc;
    d.inst    = i;
    d.illegal = !(is_i || is_s || is_b ||
                  is_u || is_j || is_r);
    unique case (1'b1)
      is_i: d.imm = {{21{i[31]}}, i[30:20]};
      is_s: d.imm = {{21{i[31]}}, i[30:25], i[11:7]};
      is_b: d.imm = {{20{i[31]}}, i[7], i[30:25],
                     i[11:8], 1'b0};
      is_u: d.imm = {i[31:12], 12'b0};
      is_j: d.imm = {{12{i[31]}}, i[19:12], i[20],
                     i[30:21], 1'b0};
      default: d.imm = 32'b0;
    endcase
    return d;
  endfunction

endpackage

module tiny_rv_decode_stage
  import tiny_rv_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_fetched_pc,
  input  logic [31:0] i_fetched_inst,
  output logic        o_pipe_stall,
  output logic        o_pipe_flush,
  output logic        o_ld_new_addr,
  output logic [31:0] o_new_addr,
  input  logic        i_ex_ready,
  input  logic        i_ex_redirect,
  input  logic [31:0] i_ex_redirect_addr,
  output logic        o_dec_valid,
  output logic [31:0] o_dec_pc,
  output logic [31:0] o_dec_inst,
  output logic [6:0]  o_dec_opcode,
  output logic [2:0]  o_dec_funct3,
  output logic [6:0]  o_dec_funct7,
  output logic [4:0]  o_dec_rd,
  output logic [4:0]  o_dec_rs1,
  output logic [4:0]  o_dec_rs2,
  output logic [31:0] o_dec_imm,
  output logic        o_dec_illegal
);

  typedef enum logic [1:0] {
    WARMUP,
    RUN,
    REDIR
  } phase_t;

  phase_t      phase_q, phase_d;
  dec_t        head_q, head_d;
  dec_t        skid_q, skid_d;
  dec_t        in_dec;
  logic [1:0]  occ_q, occ_d;
  logic        stall_d, flush_d, ld_d;
  logic [31:0] addr_d;
  logic        acc, pop;

  always_comb begin
    in_dec  = decode(i_fetched_pc, i_fetched_inst);
    acc     = (phase_q == RUN) && !o_pipe_stall &&
              (i_fetched_inst != 32'b0) &&
              !i_ex_redirect;
    pop     = (occ_q != 2'd0) && i_ex_ready;
    head_d  = head_q;
    skid_d  = skid_q;
    occ_d   = occ_q;
    phase_d = RUN;
    flush_d = 1'b0;
    ld_d    = 1'b0;
    addr_d  = o_new_addr;
    if (i_ex_redirect) begin
      occ_d   = 2'd0;
      phase_d = REDIR;
      flush_d = 1'b1;
      ld_d    = 1'b1;
      addr_d  = i_ex_redirect_addr;
    end else begin
      if (pop) head_d = skid_q;
      // New entry lands in head if head is empty
      // after this edge's pop, otherwise in skid.
      if (acc) begin
        if (occ_q == 2'd0 ||
            (occ_q == 2'd1 && pop))
          head_d = in_dec;
        else
          skid_d = in_dec;
      end
      occ_d = occ_q + {1'b0, acc} - {1'b0, pop};
      if (acc && in_dec.inst[6:0] == OP_JAL) begin
        ld_d    = 1'b1;
        addr_d  = i_fetched_pc + in_dec.imm;
        phase_d = REDIR;
      end
    end
    stall_d = (occ_d == 2'd2);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      phase_q       <= WARMUP;
      head_q        <= '0;
      skid_q        <= '0;
      occ_q         <= 2'd0;
      o_pipe_stall  <= 1'b0;
      o_pipe_flush  <= 1'b0;
      o_ld_new_addr <= 1'b0;
      o_new_addr    <= 32'b0;
    end else begin
      phase_q       <= phase_d;
      head_q        <= head_d;
      skid_q        <= skid_d;
      occ_q         <= occ_d;
      o_pipe_stall  <= stall_d;
      o_pipe_flush  <= flush_d;
      o_ld_new_addr <= ld_d;
      o_new_addr    <= addr_d;
    end
  end

  assign o_dec_valid   = (occ_q != 2'd0);
  assign o_dec_pc      = head_q.pc;
  assign o_dec_inst    = head_q.inst;
  assign o_dec_opcode  = head_q.inst[6:0];
  assign o_dec_funct3  = head_q.inst[14:12];
  assign o_dec_funct7  = head_q.inst[31:25];
  assign o_dec_rd      = head_q.inst[11:7];
  assign o_dec_rs1     = head_q.inst[19:15];
  assign o_dec_rs2     = head_q.inst[24:20];
  assign o_dec_imm     = head_q.imm;
  assign o_dec_illegal = head_q.illegal;

endmodule

// File: tb/tb_tiny_rv_decode_stage.sv
// Randomized bench for tiny_rv_decode_stage: a fetch model drives
// the DUT, a queue-based reference predicts every output each cycle.

module tb_tiny_rv_decode_stage;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_fetched_pc, i_fetched_inst;
  logic        o_pipe_stall, o_pipe_flush, o_ld_new_addr;
  logic [31:0] o_new_addr;
  logic        i_ex_ready, i_ex_redirect;
  logic [31:0] i_ex_redirect_addr;
  logic        o_dec_valid;
  logic [31:0] o_dec_pc, o_dec_inst, o_dec_imm;
  logic [6:0]  o_dec_opcode, o_dec_funct7;
  logic [2:0]  o_dec_funct3;
  logic [4:0]  o_dec_rd, o_dec_rs1, o_dec_rs2;
  logic        o_dec_illegal;

  tiny_rv_decode_stage dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_fetched_pc(i_fetched_pc),
    .i_fetched_inst(i_fetched_inst),
    .o_pipe_stall(o_pipe_stall),
    .o_pipe_flush(o_pipe_flush),
    .o_ld_new_addr(o_ld_new_addr),
    .o_new_addr(o_new_addr),
    .i_ex_ready(i_ex_ready),
    .i_ex_redirect(i_ex_redirect),
    .i_ex_redirect_addr(i_ex_redirect_addr),
    .o_dec_valid(o_dec_valid),
    .o_dec_pc(o_dec_pc), .o_dec_inst(o_dec_inst),
    .o_dec_opcode(o_dec_opcode),
    .o_dec_funct3(o_dec_funct3),
    .o_dec_funct7(o_dec_funct7),
    .o_dec_rd(o_dec_rd), .o_dec_rs1(o_dec_rs1),
    .o_dec_rs2(o_dec_rs2), .o_dec_imm(o_dec_imm),
    .o_dec_illegal(o_dec_illegal)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  int          n_assert = 0;
  int          n_fail   = 0;
  ent_t        q[$];
  int          mph;
  logic        e_stall, e_flush, e_ld;
  logic [31:0] e_addr;
  logic [31:0] fpc;
  logic        fwarm;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sext(
    input logic [31:0] v, input int n);
    return 32'($signed(v << (32 - n)) >>> (32 - n));
  endfunction

  function automatic logic [31:0] ref_imm(
    input logic [31:0] x);
    case (x[6:0])
      7'h03, 7'h13, 7'h67, 7'h0F, 7'h73:
        return sext(x >> 20, 12);
      7'h23:
        return sext(((x >> 25) << 5) | ((x >> 7) & 31), 12);
      7'h63:
        return sext((((x >> 31) & 1) << 12) |
                    (((x >> 7) & 1) << 11) |
                    (((x >> 25) & 63) << 5) |
                    (((x >> 8) & 15) << 1), 13);
      7'h37, 7'h17:
        return x & 32'hFFFF_F000;
      7'h6F:
        return sext((((x >> 31) & 1) << 20) |
                    (((x >> 12) & 255) << 12) |
                    (((x >> 20) & 1) << 11) |
                    (((x >> 21) & 1023) << 1), 21);
      default:
        return 32'h0;
    endcase
  endfunction

  function automatic logic ref_illegal(
    input logic [6:0] op);
    case (op)
      7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
      7'h37, 7'h63, 7'h67, 7'h6F, 7'h73:
        return 1'b0;
      default:
        return 1'b1;
    endcase
  endfunction

  // Instruction memory: a fixed pseudo-random word per PC.
  function automatic logic [31:0] gen(
    input logic [31:0] pc);
    logic [31:0] h;
    logic [6:0]  op;
    h = (pc ^ 32'h5A5A_1234) * 32'h9E37_79B1;
    h = h ^ (h >> 13);
    if (pc < 32'h10)
      return {h[31:20], 5'd1, 3'b000, 5'd2, 7'h13};
    case (h[3:0] % 4'd12)
      4'd0:    op = 7'h6F;
      4'd1:    op = 7'h7F;
      4'd2:    op = 7'h23;
      4'd3:    op = 7'h63;
      4'd4:    op = 7'h37;
      4'd5:    op = 7'h33;
      4'd6:    op = 7'h03;
      4'd7:    op = 7'h17;
      4'd8:    op = 7'h67;
      4'd9:    op = 7'h73;
      4'd10:   op = 7'h0F;
      default: op = 7'h13;
    endcase
    return {h[31:7], op};
  endfunction

  task automatic model_step();
    logic acc, pop;
    ent_t e;
    if (i_reset) begin
      q.delete();
      mph = 0;
      e_flush = 0; e_ld = 0; e_addr = 0;
    end else begin
      acc = (mph == 1) && !e_stall &&
            (i_fetched_inst != 0) && !i_ex_redirect;
      pop = (q.size() > 0) && i_ex_ready;
      e_flush = 0;
      e_ld    = 0;
      if (i_ex_redirect) begin
        q.delete();
        e_flush = 1; e_ld = 1;
        e_addr  = i_ex_redirect_addr;
        mph = 2;
      end else begin
        if (pop) void'(q.pop_front());
        mph = 1;
        if (acc) begin
          e.pc = i_fetched_pc;
          e.inst = i_fetched_inst;
          q.push_back(e);
          if (i_fetched_inst[6:0] == 7'h6F) begin
            e_ld = 1;
            e_addr = i_fetched_pc +
                     ref_imm(i_fetched_inst);
            mph = 2;
          end
        end
      end
    end
    e_stall = (q.size() == 2);
  endtask

  task automatic compare(input logic after_rst);
    logic [31:0] x;
    check("valid", 32'(o_dec_valid), 32'(q.size() != 0));
    check("stall", 32'(o_pipe_stall), 32'(e_stall));
    check("flush", 32'(o_pipe_flush), 32'(e_flush));
    check("ld_new_addr", 32'(o_ld_new_addr), 32'(e_ld));
    if (e_ld) check("new_addr", o_new_addr, e_addr);
    if (after_rst) begin
      check("rst_pc", o_dec_pc, 0);
      check("rst_inst", o_dec_inst, 0);
      check("rst_imm", o_dec_imm, 0);
      check("rst_new_addr", o_new_addr, 0);
      check("rst_illegal", 32'(o_dec_illegal), 0);
    end
    if (q.size() != 0) begin
      x = q[0].inst;
      check("pc", o_dec_pc, q[0].pc);
      check("inst", o_dec_inst, x);
      check("opcode", 32'(o_dec_opcode), x & 127);
      check("funct3", 32'(o_dec_funct3), (x >> 12) & 7);
      check("funct7", 32'(o_dec_funct7), x >> 25);
      check("rd", 32'(o_dec_rd), (x >> 7) & 31);
      check("rs1", 32'(o_dec_rs1), (x >> 15) & 31);
      check("rs2", 32'(o_dec_rs2), (x >> 20) & 31);
      check("imm", o_dec_imm, ref_imm(x));
      check("illegal", 32'(o_dec_illegal),
            32'(ref_illegal(x[6:0])));
    end
  endtask

  initial begin
    logic        quiet, bub, ld_p, st_p;
    logic [31:0] addr_p;
    i_reset = 1;
    i_fetched_pc = 0; i_fetched_inst = 0;
    i_ex_ready = 0; i_ex_redirect = 0;
    i_ex_redirect_addr = 0;
    model_step();
    repeat (2) @(posedge i_clk);
    #1;
    compare(1'b1);
    fpc = 0; fwarm = 1;
    for (int c = 0; c < 3000; c++) begin
      quiet = (c < 8) || (c >= 1500 && c < 1508);
      bub = !quiet && ($urandom_range(0, 7) == 0);
      i_reset = (c == 1500);
      i_fetched_pc = fpc;
      i_fetched_inst = bub ? 32'h0 : gen(fpc);
      if (quiet)
        i_ex_ready = 1;
      else if ((c / 40) % 3 == 2)
        i_ex_ready = ($urandom_range(0, 3) == 0);
      else
        i_ex_ready = ($urandom_range(0, 3) != 0);
      i_ex_redirect = !quiet &&
                      ($urandom_range(0, 24) == 0);
      i_ex_redirect_addr =
        32'($urandom_range(0, 1023)) << 2;
      model_step();
      ld_p = o_ld_new_addr;
      addr_p = o_new_addr;
      st_p = o_pipe_stall;
      @(posedge i_clk);
      #1;
      compare(i_reset);
      if (i_reset) begin
        fpc = 0; fwarm = 1;
      end else if (fwarm) begin
        fwarm = 0;
      end else if (ld_p) begin
        fpc = addr_p;
      end else if (!st_p && !bub) begin
        fpc = fpc + 4;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
